// File: rtl/register_write_demux.sv
// Write-back demultiplexer for the 4-register datapath.
// One WIDTH-bit result is steered into c0..c3 by a 2-bit destination.
// c3 doubles as the program counter: it self-increments on every step
// that does not load it, and the wrap from all-ones to zero is flagged.
module register_write_demux #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] REG_INIT = '0,
  parameter logic [WIDTH-1:0] PC_INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             write_en,
  input  logic             select_a,
  input  logic             select_b,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] c0,
  output logic [WIDTH-1:0] c1,
  output logic [WIDTH-1:0] c2,
  output logic [WIDTH-1:0] c3,
  output logic [3:0]       wr_strobe,
  output logic             pc_wrap
);

  logic [1:0] dest;
  logic [3:0] dest_onehot;
  logic [3:0] load;
  logic       pc_inc;

  // Program-counter increment, modulo 2^WIDTH; the carry is reported separately.
  function automatic logic [WIDTH-1:0] pc_next(input logic [WIDTH-1:0] pc);
    return pc + WIDTH'(1);
  endfunction

  // Carry out of the increment: only an all-ones counter wraps.
  function automatic logic pc_carry(input logic [WIDTH-1:0] pc);
    return &pc;
  endfunction

  assign dest = {select_b, select_a};

  // Destination decode, same encoding as the read selector: (b,a) 00->c0 .. 11->c3.
  always_comb begin
    dest_onehot = 4'b0000;
    dest_onehot[dest] = 1'b1;
  end

  // A register loads only on a qualifying step with writes enabled.
  assign load   = (step && write_en) ? dest_onehot : 4'b0000;
  assign pc_inc = step && !load[3];

  // General-purpose registers c0..c2: load from data_in when addressed, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c0 <= REG_INIT;
      c1 <= REG_INIT;
      c2 <= REG_INIT;
    end else begin
      if (load[0]) c0 <= data_in;
      if (load[1]) c1 <= data_in;
      if (load[2]) c2 <= data_in;
    end
  end

  // Program counter c3: a jump (load) takes priority over the self-increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c3 <= PC_INIT;
    end else if (load[3]) begin
      c3 <= data_in;
    end else if (pc_inc) begin
      c3 <= pc_next(c3);
    end
  end

  // Status pulses: one-hot strobe for the register just loaded, and the PC wrap flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_strobe <= 4'b0000;
      pc_wrap   <= 1'b0;
    end else begin
      wr_strobe <= load;
      pc_wrap   <= pc_inc && pc_carry(c3);
    end
  end

endmodule

// File: tb/tb_register_write_demux.sv
// Directed bench for register_write_demux (WIDTH=4, zero reset values).
module tb_register_write_demux;

  logic       clk;
  logic       reset;
  logic       step;
  logic       write_en;
  logic       select_a;
  logic       select_b;
  logic [3:0] data_in;
  logic [3:0] c0, c1, c2, c3;
  logic [3:0] wr_strobe;
  logic       pc_wrap;

  int checks = 0;
  int errors = 0;

  register_write_demux #(
    .WIDTH   (4),
    .REG_INIT(4'h0),
    .PC_INIT (4'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .step     (step),
    .write_en (write_en),
    .select_a (select_a),
    .select_b (select_b),
    .data_in  (data_in),
    .c0       (c0),
    .c1       (c1),
    .c2       (c2),
    .c3       (c3),
    .wr_strobe(wr_strobe),
    .pc_wrap  (pc_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected full state in one call.
  task automatic check_all(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2, input logic [3:0] e3,
                           input logic [3:0] estb, input logic ewrap);
    check({tag, ".c0"}, 32'(c0), 32'(e0));
    check({tag, ".c1"}, 32'(c1), 32'(e1));
    check({tag, ".c2"}, 32'(c2), 32'(e2));
    check({tag, ".c3"}, 32'(c3), 32'(e3));
    check({tag, ".wr_strobe"}, 32'(wr_strobe), 32'(estb));
    check({tag, ".pc_wrap"}, 32'(pc_wrap), 32'(ewrap));
  endtask

  // Apply inputs away from the edge, then advance one clock and settle.
  task automatic cycle(input logic s, input logic w, input logic a, input logic b,
                       input logic [3:0] d);
    step     = s;
    write_en = w;
    select_a = a;
    select_b = b;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    step     = 1'b0;
    write_en = 1'b0;
    select_a = 1'b0;
    select_b = 1'b0;
    data_in  = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b0);
    reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    check_all("idle_after_reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b0);

    // Test 1: build c1=9, c3=5, then assert reset between edges.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h9);
    check_all("t1_load_c1", 4'h0, 4'h9, 4'h0, 4'h1, 4'b0010, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'h5);
    check_all("t1_jump_c3", 4'h0, 4'h9, 4'h0, 4'h5, 4'b1000, 1'b0);
    step = 1'b0;
    write_en = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check_all("t1_async_reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h7);
    check_all("t1_reset_held1", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    check_all("t1_reset_held2", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b0);
    step = 1'b0;
    reset = 1'b0;

    // Test 2: load c1 with A; PC increments.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'hA);
    check_all("t2_load_c1", 4'h0, 4'hA, 4'h0, 4'h1, 4'b0010, 1'b0);

    // Test 3: jump overrides increment.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'h7);
    check_all("t3_set_pc7", 4'h0, 4'hA, 4'h0, 4'h7, 4'b1000, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'h3);
    check_all("t3_jump", 4'h0, 4'hA, 4'h0, 4'h3, 4'b1000, 1'b0);

    // Test 4: PC wraps F -> 0 with a single-cycle pulse.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
    check_all("t4_set_pcF", 4'h0, 4'hA, 4'h0, 4'hF, 4'b1000, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h5);
    check_all("t4_wrap", 4'h0, 4'hA, 4'h0, 4'h0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    check_all("t4_wrap_clears", 4'h0, 4'hA, 4'h0, 4'h0, 4'b0000, 1'b0);

    // Test 5: step=0 freezes everything regardless of write inputs.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h6);
      check_all($sformatf("t5_frozen%0d", i), 4'h0, 4'hA, 4'h0, 4'h0, 4'b0000, 1'b0);
    end

    // Test 6: all four destinations back-to-back.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
    check_all("t6_c0", 4'h1, 4'hA, 4'h0, 4'h1, 4'b0001, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h2);
    check_all("t6_c1", 4'h1, 4'h2, 4'h0, 4'h2, 4'b0010, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'h3);
    check_all("t6_c2", 4'h1, 4'h2, 4'h3, 4'h3, 4'b0100, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'h4);
    check_all("t6_c3", 4'h1, 4'h2, 4'h3, 4'h4, 4'b1000, 1'b0);

    // Rewriting the same value still strobes.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'h3);
    check_all("same_value", 4'h1, 4'h2, 4'h3, 4'h5, 4'b0100, 1'b0);

    // write_en=0 ignores select/data, PC still advances.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'hE);
    check_all("we0_ignored", 4'h1, 4'h2, 4'h3, 4'h6, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
